// File: rtl/sseg_code_gen_pkg.sv
// Shared character codes, mode encodings and BCD helpers for the seven-segment
// code generator and its double-dabble converter.
package sseg_code_gen_pkg;

  localparam int unsigned DIGITS  = 5;
  localparam int unsigned CODE_W  = 5;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned BCD_W   = DIGITS * NIB_W;
  localparam int unsigned CODES_W = DIGITS * CODE_W;

  // Character-code space consumed by SSeg; digits 0-9 map to themselves.
  localparam logic [CODE_W-1:0] C_D   = 5'd13;
  localparam logic [CODE_W-1:0] C_E   = 5'd14;
  localparam logic [CODE_W-1:0] C_N   = 5'd19;
  localparam logic [CODE_W-1:0] C_O   = 5'd20;
  localparam logic [CODE_W-1:0] C_R   = 5'd22;
  localparam logic [CODE_W-1:0] C_U   = 5'd25;
  localparam logic [CODE_W-1:0] C_OFF = 5'd27;

  typedef enum logic [1:0] {
    MODE_NUM  = 2'd0,
    MODE_RUN  = 2'd1,
    MODE_DONE = 2'd2,
    MODE_ERR  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_FORMAT  = 2'd2
  } state_e;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd[k*NIB_W +: NIB_W] >= 4'd5)
        r[k*NIB_W +: NIB_W] = bcd[k*NIB_W +: NIB_W] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/sseg_code_gen_bin2bcd_serial.sv
// Serial double-dabble binary-to-BCD converter: one add-3/shift per step,
// 'last' is high while the final step of the word is being taken.
module sseg_code_gen_bin2bcd_serial
  import sseg_code_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] value,
  output logic [BCD_W-1:0] bcd,
  output logic             last
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] bcd_adj;

  assign bcd_adj = bcd_add3(bcd);

  always_ff @(posedge clk) begin
    if (!rstN) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      last  <= 1'b0;
    end else if (load) begin
      shreg <= value;
      bcd   <= '0;
      cnt   <= '0;
      last  <= (WIDTH == 1);
    end else if (step) begin
      // Shifting the concatenation drops the (always zero) top BCD bit.
      {bcd, shreg} <= {bcd_adj, shreg} << 1;
      cnt          <= cnt + CNT_W'(1);
      last         <= (cnt == CNT_W'(WIDTH - 2));
    end
  end

endmodule

// File: rtl/sseg_code_gen.sv
// Start/busy front end producing five SSeg character codes from a binary
// value (with optional leading-zero blanking) or a fixed status message.
module sseg_code_gen
  import sseg_code_gen_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic [WIDTH-1:0]   value,
  input  logic [1:0]         mode,
  input  logic               blank_lz,
  output logic               busy,
  output logic               done,
  output logic [CODES_W-1:0] codes
);

  state_e             state, state_nx;
  mode_e              mode_q, mode_nx;
  logic               blank_q, blank_nx;
  logic               busy_nx, done_nx;
  logic [CODES_W-1:0] codes_nx, num_codes, fmt_codes;
  logic               load_c, step_c, last;
  logic [BCD_W-1:0]   bcd;
  logic [NIB_W-1:0]   nib;
  logic               lead;

  sseg_code_gen_bin2bcd_serial #(.WIDTH(WIDTH)) u_bin2bcd (
    .clk   (clk),
    .rstN  (rstN),
    .load  (load_c),
    .step  (step_c),
    .value (value),
    .bcd   (bcd),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state   <= S_IDLE;
      mode_q  <= MODE_NUM;
      blank_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      codes   <= {DIGITS{C_OFF}};
    end else begin
      state   <= state_nx;
      mode_q  <= mode_nx;
      blank_q <= blank_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      codes   <= codes_nx;
    end
  end

  // Number digits, scanning down from the top while still inside leading zeros.
  always_comb begin
    num_codes = '0;
    nib       = '0;
    lead      = blank_q;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      nib = bcd[k*NIB_W +: NIB_W];
      if (nib != '0) lead = 1'b0;
      if (lead && (k != 0)) num_codes[k*CODE_W +: CODE_W] = C_OFF;
      else                  num_codes[k*CODE_W +: CODE_W] = {1'b0, nib};
    end
  end

  always_comb begin
    fmt_codes = num_codes;
    case (mode_q)
      MODE_RUN:  fmt_codes = {C_OFF, C_OFF, C_R, C_U, C_N};
      MODE_DONE: fmt_codes = {C_OFF, C_D, C_O, C_N, C_E};
      MODE_ERR:  fmt_codes = {C_OFF, C_OFF, C_E, C_R, C_R};
      default:   fmt_codes = num_codes;
    endcase
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    blank_nx = blank_q;
    busy_nx  = busy;
    done_nx  = 1'b0;
    codes_nx = codes;
    load_c   = 1'b0;
    step_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mode_nx  = mode_e'(mode);
          blank_nx = blank_lz;
          busy_nx  = 1'b1;
          if (mode_e'(mode) == MODE_NUM) begin
            load_c   = 1'b1;
            state_nx = S_CONVERT;
          end else begin
            state_nx = S_FORMAT;
          end
        end
      end
      S_CONVERT: begin
        step_c = 1'b1;
        if (last) state_nx = S_FORMAT;
      end
      S_FORMAT: begin
        codes_nx = fmt_codes;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sseg_code_gen.sv
// Directed bench for sseg_code_gen: expected codes are queued at request time
// and checked by a monitor whenever done pulses.
module tb_sseg_code_gen;

  localparam int unsigned WIDTH = 16;
  localparam logic [24:0] ALL_OFF = {5{5'd27}};

  logic             clk = 1'b0;
  logic             rstN;
  logic             start;
  logic [WIDTH-1:0] value;
  logic [1:0]       mode;
  logic             blank_lz;
  logic             busy;
  logic             done;
  logic [24:0]      codes;

  int tests    = 0;
  int fails    = 0;
  int done_cnt = 0;
  logic [24:0] sb[$];

  always #5 clk = ~clk;

  sseg_code_gen #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .start    (start),
    .value    (value),
    .mode     (mode),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .codes    (codes)
  );

  // Reference: decimal digits by division; digit k is a leading zero iff v < 10^k.
  function automatic logic [24:0] model(input int unsigned v, input int m, input bit b);
    int unsigned d[5];
    int unsigned p;
    logic [24:0] r;
    p = 1;
    for (int k = 0; k < 5; k++) begin
      d[k] = (v / p) % 10;
      if (b && k != 0 && v < p) d[k] = 27;
      p = p * 10;
    end
    case (m)
      1: d = '{19, 25, 22, 27, 27};
      2: d = '{14, 19, 20, 13, 27};
      3: d = '{22, 22, 14, 27, 27};
      default: ;
    endcase
    r = '0;
    for (int k = 0; k < 5; k++) r[5*k +: 5] = 5'(d[k]);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rstN && done) begin
      done_cnt++;
      chk("sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) chk("codes", 32'(codes), 32'(sb.pop_front()));
    end
  end

  task automatic issue(input int unsigned v, input int m, input bit b);
    @(negedge clk);
    start    = 1'b1;
    value    = WIDTH'(v);
    mode     = 2'(m);
    blank_lz = b;
    sb.push_back(model(v, m, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge (or later, with a reduced latency).
  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    bit busy_ok;
    bit hold_ok;
    logic [24:0] c0;
    n = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    c0 = codes;
    chk({tag, "_busy_start"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (!done) begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (codes !== c0)  hold_ok = 1'b0;
      end
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({tag, "_codes_held"}, 32'(hold_ok), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int dc0;
    int n;
    rstN = 1'b0; start = 1'b0; value = '0; mode = '0; blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_codes", 32'(codes), 32'(ALL_OFF));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rstN = 1'b1;

    issue(0, 0, 1'b1);      wait_done("zero", 17);
    issue(65535, 0, 1'b0);  wait_done("max", 17);
    issue(1234, 0, 1'b0);   wait_done("n1234", 17);
    issue(1234, 0, 1'b1);   wait_done("n1234_blank", 17);
    issue(0, 2, 1'b0);      wait_done("msg_done", 1);
    issue(0, 3, 1'b0);      wait_done("msg_err", 1);
    issue(0, 1, 1'b1);      wait_done("msg_run", 1);
    issue(10000, 0, 1'b1);  wait_done("n10000", 17);

    // Start while busy is ignored.
    dc0 = done_cnt;
    issue(4321, 0, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; value = WIDTH'(999); mode = 2'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore", 12);
    repeat (20) @(negedge clk);
    chk("ignore_done_count", 32'(done_cnt - dc0), 32'd1);

    // Reset mid-conversion aborts without a done.
    dc0 = done_cnt;
    issue(777, 0, 1'b1);
    repeat (7) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    chk("abort_codes", 32'(codes), 32'(ALL_OFF));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rstN = 1'b1;
    sb.delete();
    repeat (25) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    issue(42, 0, 1'b1);     wait_done("after_rst", 17);

    // Start held through the done cycle is accepted on the next edge.
    @(negedge clk);
    start = 1'b1; value = WIDTH'(7); mode = 2'd0; blank_lz = 1'b1;
    sb.push_back(model(7, 0, 1'b1));
    @(negedge clk);
    value = WIDTH'(8);
    sb.push_back(model(8, 0, 1'b1));
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_latency", 32'(n), 32'd17);
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_second", 17);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sseg_code_gen.md
# sseg_code_gen

Sequential front end for the seven-segment display chain. It accepts a 16-bit binary value, or a status-message request, over a start/busy handshake and produces five 5-bit character codes, one per digit, in the character-code space consumed by `SSeg`. Number conversion uses serial double-dabble. Leading-zero blanking is optional. It sits between the processor status/result registers and the five `SSeg` instances on the board.

## Interface
- `WIDTH`, 16, binary input width. The design is fixed to `DIGITS` = 5, so `WIDTH` ≤ 16.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rstN`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `value`  in  WIDTH  binary number; latched when `start` is accepted.
- `mode`  in  2  0 = number, 1 = "run", 2 = "done", 3 = "Err"; latched with `start`.
- `blank_lz`  in  1  blank leading zeros when 1; latched with `start`.
- `busy`  out  1  high while a request is in progress.
- `done`  out  1  one-cycle pulse in the cycle new codes appear.
- `codes`  out  25  digit k occupies bits `[5k+4:5k]`; digit 0 is least significant.

## Operation
- Character codes: 0–9 are decimal digits, d = 13, E/e = 14, n = 19, o = 20, r = 22, u = 25, off = 27.
- States: IDLE, CONVERT, FORMAT.
- IDLE → CONVERT when `start` is high and `mode` = 0.
- IDLE → FORMAT when `start` is high and `mode` ≠ 0.
- CONVERT → FORMAT after exactly `WIDTH` shift cycles.
- FORMAT → IDLE always.
- CONVERT, per cycle:
  - For each 4-bit BCD nibble ≥ 5, add 3.
  - Then shift {bcd[19:0], shreg} left by 1.
  - The 20-bit BCD accumulator and bit counter clear on acceptance.
- FORMAT, number mode:
  - digit k = BCD nibble k.
  - If `blank_lz` is set, every zero nibble above the highest non-zero nibble becomes off.
  - Digit 0 is never blanked.
- FORMAT, message modes (digit4..digit0):
  - "run" = off, off, r, u, n.
  - "done" = off, d, o, n, e.
  - "Err" = off, off, E, r, r.
- `codes` is registered and changes only in the cycle `done` pulses. It holds its value otherwise, including while busy.
- `start` while busy is ignored; it is neither queued nor errored.
- Reset: `codes` = all off (27 in every digit), `busy` = 0, `done` = 0, state IDLE, accumulators cleared.

## Timing
- Edge E0 accepts `start`; `busy` = 1 from E0.
- Number mode:
  - CONVERT spans E1..E16.
  - FORMAT updates `codes` and sets `done` = 1 and `busy` = 0 at E17.
  - Latency is 17 cycles.
- Message mode: `codes`, `done` and `busy` = 0 update at E1 (latency 1).
- `done` is high for exactly one cycle.
- `start` held high during the `done` cycle is accepted at the next edge; back-to-back throughput is 18 cycles per number.
- `rstN` low at any edge, including mid-CONVERT, aborts the request. Outputs take reset values at that edge, and no `done` is produced for the aborted request.
- Inputs other than `start` need to be valid only at the accepting edge.

## Structure
- Shared header `sseg_codes.vh` holds the character-code localparams (digits, d, E, n, o, r, u, off). It is included by both this block and `SSeg`, replacing `SSeg`'s local copies.
- Mode encodings live in the same header.
- One sub-module, `bin2bcd_serial`, contains the shift register, the BCD accumulator, the add-3 correction and the bit counter. It exposes `load`, `step`, `bcd[19:0]` and a `last` flag.
- The top level holds the FSM, the formatting/blanking mux and the `codes` register.

## Test plan
- Reset, then `value` = 0, `mode` = 0, `blank_lz` = 1 → after 17 cycles `done` pulses; `codes` digits4..0 = 27, 27, 27, 27, 0.
- `value` = 65535, `blank_lz` = 0 → digits4..0 = 6, 5, 5, 3, 5 at E17; `busy` high E0..E16.
- `value` = 1234 with `blank_lz` = 0, then `blank_lz` = 1 → 0, 1, 2, 3, 4, then 27, 1, 2, 3, 4.
- `mode` = 2 → `done` at E1; digits = 27, 13, 20, 19, 14. Then `mode` = 3 → 27, 27, 14, 22, 22.
- `start` with `value` = 999 at E5 of a 4321 conversion → ignored; result is 4321, and only one `done` pulse occurs.
- `rstN` low at E8 of a conversion → `codes` = all 27, `busy` = 0, no `done`; a following request for 42 yields 27, 27, 27, 4, 2 with `blank_lz` = 1.
